// File: rtl/seq_frame_pkg.sv
// Shared definitions for the flag/data sequence receiver: FSM states, error codes,
// default pattern bytes and the frame length.
package seq_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_LONG = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DATA  = 2'd1;
  localparam logic [1:0] ERR_SHORT = 2'd2;
  localparam logic [1:0] ERR_LONG  = 2'd3;

  localparam logic [7:0] DEF_PAT0 = 8'd7;
  localparam logic [7:0] DEF_PAT1 = 8'd2;
  localparam logic [7:0] DEF_PAT2 = 8'd5;

  localparam int FRAME_LEN = 3;

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_frame_rx.sv
// Frame receiver: checks runs of flag_in=1 bytes against a 3-byte pattern and reports per-frame
// verdicts. Optional inter-frame gap checking is enabled with `define SEQ_RX_GAP_CHECK_EN.
module seq_frame_rx
  import seq_frame_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                CNT_W   = 8,
  parameter logic [DATA_W-1:0] PAT0    = DATA_W'(DEF_PAT0),
  parameter logic [DATA_W-1:0] PAT1    = DATA_W'(DEF_PAT1),
  parameter logic [DATA_W-1:0] PAT2    = DATA_W'(DEF_PAT2),
  parameter int                MIN_GAP = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // flag_in is a valid with no ready: every flag_in=1 cycle delivers one byte that is always taken.
  input  logic                          flag_in,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          frame_done,
  output logic                          frame_ok,
  output logic [FRAME_LEN*DATA_W-1:0]   frame_data,
  output logic [1:0]                    err_code,
  output logic [CNT_W-1:0]              ok_cnt,
  output logic [CNT_W-1:0]              err_cnt,
  output logic [2:0]                    o_dbg_state
);

  state_t              r_state, w_state_nxt;
  logic                w_start, w_end, w_gap_bad;
  logic [1:0]          w_err;
  logic [DATA_W-1:0]   r_b0, r_b1, r_b2;
  logic                r_miss;
  logic                r_done, r_ok;
  logic [1:0]          r_err;
  logic [FRAME_LEN*DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_IDLE: if (flag_in) begin w_state_nxt = ST_B1; w_start = 1'b1; end
      ST_B1:   if (flag_in) w_state_nxt = ST_B2; else begin w_state_nxt = ST_IDLE; w_end = 1'b1; end
      ST_B2:   if (flag_in) w_state_nxt = ST_B3; else begin w_state_nxt = ST_IDLE; w_end = 1'b1; end
      ST_B3:   if (flag_in) w_state_nxt = ST_LONG; else begin w_state_nxt = ST_IDLE; w_end = 1'b1; end
      ST_LONG: if (!flag_in) begin w_state_nxt = ST_IDLE; w_end = 1'b1; end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Long (or too-close) outranks short, which outranks a content mismatch.
  always_comb begin
    w_err = ERR_NONE;
    if (r_state == ST_LONG || w_gap_bad)          w_err = ERR_LONG;
    else if (r_state == ST_B1 || r_state == ST_B2) w_err = ERR_SHORT;
    else if (r_miss)                               w_err = ERR_DATA;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b0   <= '0;
      r_b1   <= '0;
      r_b2   <= '0;
      r_miss <= 1'b0;
    end else if (w_start) begin
      r_b0   <= data_in;
      r_b1   <= '0;
      r_b2   <= '0;
      r_miss <= (data_in != PAT0);
    end else if (flag_in && r_state == ST_B1) begin
      r_b1   <= data_in;
      r_miss <= r_miss | (data_in != PAT1);
    end else if (flag_in && r_state == ST_B2) begin
      r_b2   <= data_in;
      r_miss <= r_miss | (data_in != PAT2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_ok   <= 1'b0;
      r_err  <= ERR_NONE;
      r_data <= '0;
    end else begin
      r_done <= w_end;
      if (w_end) begin
        r_ok   <= (w_err == ERR_NONE);
        r_err  <= w_err;
        r_data <= {r_b0, r_b1, r_b2};
      end
    end
  end

`ifdef SEQ_RX_GAP_CHECK_EN
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  logic [GAP_W-1:0] w_gap_q;
  logic             r_seen, r_gap_bad;

  // Counts flag-low cycles; its value before a frame's first byte is the preceding gap.
  seq_sat_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!flag_in && (w_gap_q < GAP_W'(MIN_GAP))),
    .clear (flag_in),
    .q     (w_gap_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen    <= 1'b0;
      r_gap_bad <= 1'b0;
    end else if (w_start) begin
      r_seen    <= 1'b1;
      r_gap_bad <= r_seen && (w_gap_q < GAP_W'(MIN_GAP));
    end
  end

  assign w_gap_bad = r_gap_bad;
`else
  assign w_gap_bad = 1'b0;
`endif

  seq_sat_cnt #(.W(CNT_W)) u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_end && (w_err == ERR_NONE)),
    .clear (1'b0),
    .q     (ok_cnt)
  );

  seq_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_end && (w_err != ERR_NONE)),
    .clear (1'b0),
    .q     (err_cnt)
  );

  assign frame_done  = r_done;
  assign frame_ok    = r_ok;
  assign err_code    = r_err;
  assign frame_data  = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_frame_rx.sv
// Bench for seq_frame_rx: table of frames with expected verdicts, scoreboard queue checked on
// every frame_done, plus reset-abort, gap and counter-saturation sequences.
module tb_seq_frame_rx;

  logic        clk;
  logic        rst_n;
  logic        flag_in;
  logic [7:0]  data_in;
  logic        frame_done;
  logic        frame_ok;
  logic [23:0] frame_data;
  logic [1:0]  err_code;
  logic [7:0]  ok_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ok   = 0;
  int exp_err  = 0;
  logic [25:0] exp_q[$];

  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          gap;
    logic [1:0]  exp_err;
    logic [23:0] exp_data;
  } vec_t;

  vec_t tbl[11];

  seq_frame_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flag_in     (flag_in),
    .data_in     (data_in),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_data  (frame_data),
    .err_code    (err_code),
    .ok_cnt      (ok_cnt),
    .err_cnt     (err_cnt),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [31:0] b, input int gap);
    for (int i = 0; i < n; i++) begin
      flag_in = 1'b1;
      data_in = b[31-8*i -: 8];
      step();
    end
    for (int i = 0; i < gap; i++) begin
      flag_in = 1'b0;
      data_in = 8'($urandom_range(0, 255));
      step();
    end
  endtask

  task automatic push_exp(input logic [1:0] e, input logic [23:0] d);
    exp_q.push_back({e, d});
  endtask

  // scoreboard: pop one expectation per frame_done, track counters
  always @(negedge clk) begin
    logic [25:0] e;
    if (!rst_n) begin
      exp_ok  = 0;
      exp_err = 0;
    end else if (frame_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got frame_data 0x%0h expected no frame at %0t",
                 frame_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (e[25:24] == 2'd0) begin
          if (exp_ok < 255) exp_ok++;
        end else begin
          if (exp_err < 255) exp_err++;
        end
        check("err_code", 32'(err_code), 32'(e[25:24]));
        check("frame_ok", 32'(frame_ok), 32'(e[25:24] == 2'd0));
        check("frame_data", 32'(frame_data), 32'(e[23:0]));
        check("ok_cnt", 32'(ok_cnt), 32'(exp_ok));
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
      end
    end
  end

  initial begin
    int wait_cyc;
    logic [1:0] gap_err;

    tbl[0]  = '{3, 32'h07020500, 5, 2'd0, 24'h070205};
    tbl[1]  = '{3, 32'h07020500, 5, 2'd0, 24'h070205};
    tbl[2]  = '{3, 32'h07020500, 5, 2'd0, 24'h070205};
    tbl[3]  = '{3, 32'h07020500, 5, 2'd0, 24'h070205};
    tbl[4]  = '{3, 32'h07030500, 4, 2'd1, 24'h070305};
    tbl[5]  = '{2, 32'h07020000, 3, 2'd2, 24'h070200};
    tbl[6]  = '{4, 32'h07020509, 3, 2'd3, 24'h070205};
    tbl[7]  = '{1, 32'h09000000, 3, 2'd2, 24'h090000};
    tbl[8]  = '{3, 32'h01020500, 3, 2'd1, 24'h010205};
    tbl[9]  = '{4, 32'h07020505, 3, 2'd3, 24'h070205};
    tbl[10] = '{3, 32'h07020400, 5, 2'd1, 24'h070204};

    rst_n   = 1'b0;
    flag_in = 1'b0;
    data_in = 8'h00;
    step();
    step();
    @(negedge clk);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_frame_data", 32'(frame_data), 32'd0);
    check("rst_ok_cnt", 32'(ok_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      push_exp(tbl[i].exp_err, tbl[i].exp_data);
      send_frame(tbl[i].n, tbl[i].bytes, tbl[i].gap);
    end
    @(negedge clk);
    check("hold_frame_done", 32'(frame_done), 32'd0);
    check("hold_err_code", 32'(err_code), 32'd1);
    check("hold_frame_ok", 32'(frame_ok), 32'd0);
    check("hold_frame_data", 32'(frame_data), 32'h070204);
    check("table_ok_cnt", 32'(ok_cnt), 32'd4);
    check("table_err_cnt", 32'(err_cnt), 32'd7);
    step();

    // reset one cycle after byte 2 of a frame: no verdict, counters cleared
    send_frame(2, 32'h07020000, 0);
    flag_in = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    @(negedge clk);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    check("abort_ok_cnt", 32'(ok_cnt), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    check("abort_frame_data", 32'(frame_data), 32'd0);
    step();
    push_exp(2'd0, 24'h070205);
    send_frame(3, 32'h07020500, 3);
    @(negedge clk);
    check("post_abort_ok_cnt", 32'(ok_cnt), 32'd1);
    step();

    // back-to-back with a 1-cycle gap
`ifdef SEQ_RX_GAP_CHECK_EN
    gap_err = 2'd3;
`else
    gap_err = 2'd0;
`endif
    push_exp(2'd0, 24'h070205);
    send_frame(3, 32'h07020500, 1);
    push_exp(gap_err, 24'h070205);
    send_frame(3, 32'h07020500, 3);

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      push_exp(2'd0, 24'h070205);
      send_frame(3, 32'h07020500, 2);
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending frames expected 0", exp_q.size());
    end
    @(negedge clk);
    check("sat_ok_cnt", 32'(ok_cnt), 32'd255);
    check("sat_err_cnt", 32'(err_cnt), 32'(gap_err != 2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
